light_pattern_engine: RTL and testbench
=======================================

Name: light_pattern_engine

Overview:
- Parametrised successor to the board's fixed 8-LED pattern generator. Adds an integrated speed-selectable tick divider, four selectable patterns, configurable output width and pause/resume control.
- Sits between the push-button synchroniser (supplies one-cycle Play pulses) and the LED/output pins.
- Drives WIDTH-bit out and a Step strobe for downstream scoring/sound logic.

Parameters:
- WIDTH, 8, pattern/output width; legal range 2..32.
- DIV_STEP, 6250000, Clk cycles per speed unit; tick period = (Speed+1)*DIV_STEP cycles. Benches use 2.
- DIV_BITS, 27, divider counter width; must hold 16*DIV_STEP-1.
- LFSR_TAPS, 8'hB8, Galois LFSR feedback mask, WIDTH bits wide.

Ports:
- Clk  in  1  system clock; single clock domain.
- Rst  in  1  synchronous, active-high reset.
- Speed  in  4  tick rate select; 0 fastest, 15 slowest.
- Mode  in  2  0 rotate, 1 bounce, 2 count, 3 LFSR.
- Begin  in  1  level; high runs the engine, low forces idle.
- Play  in  1  pre-synchronised one-cycle pulse; toggles run/pause.
- out  out  WIDTH  registered pattern.
- Step  out  1  one-cycle pulse on the edge that out advances.
- Running  out  1  high in RUN state.

Behaviour:
- Rst (sync, high): state=IDLE, out=0, Step=0, Running=0, divider=0, latched mode=0. Rst overrides all inputs.
- States are IDLE, RUN and PAUSE.
  - IDLE: out=0. When Begin=1, latch Mode, load seed into out and load divider with (Speed+1)*DIV_STEP-1, then go to RUN. Play is ignored in IDLE, including a Play in the same cycle as the start.
  - RUN: divider decrements each cycle. When the divider is 0, the pattern advances (out and Step update on the same edge) and the divider reloads using the current Speed. A Play pulse goes to PAUSE; in that cycle no advance occurs even if the divider is 0, and the divider holds.
  - PAUSE: out and divider hold. A Play pulse goes to RUN, and counting resumes from the held divider value.
  - RUN or PAUSE with Begin=0: go to IDLE and set out=0 on the next edge. Begin=0 has priority over Play and over a tick in the same cycle.
- Speed changes take effect only at the next divider reload. Mode changes while running are ignored until the next IDLE→RUN.
- Patterns (seed; next value):
  - Rotate: seed 1; rotate left, MSB wraps to bit 0.
  - Bounce: seed 1, direction=left; shift one position. Reverse direction when the bit reaches MSB (while going left) or bit 0 (while going right). The endpoint is shown for exactly one step, with no double-display.
  - Count: seed 0; out+1 modulo 2^WIDTH; wraps all-ones to 0.
  - LFSR: seed 1; Galois shift: next = (out>>1) ^ (out[0] ? LFSR_TAPS : 0). If out is ever 0, reload 1.
- Step is 0 except in the advance cycle. Running = (state==RUN).
- Tick latency: the first advance occurs exactly (Speed+1)*DIV_STEP cycles after the IDLE→RUN edge.

Decomposition:
- Shared package holds:
  - mode encodings: MODE_ROTATE=0, MODE_BOUNCE=1, MODE_COUNT=2, MODE_LFSR=3;
  - state encodings: ST_IDLE, ST_RUN, ST_PAUSE.
- One sub-module is natural: pattern_tick_div (Clk, Rst, load, enable, Speed → tick), a reloadable down-counter with terminal-count output.
- Pattern next-state logic stays in the top block as a combinational case on the latched mode.

Test Plan:
1. WIDTH=8, DIV_STEP=2, Speed=0, Mode=0: Rst, then Begin=1 → out=01 after one edge; Step every 2 cycles; out steps 02,04,…,80,01 (wrap).
2. Mode=1, Speed=1 → Step every 4 cycles; out sequence 01,02,…,80,40,…,01,02; 80 and 01 each appear exactly once per sweep.
3. Mode=2, Speed=0 → 00,01,…,FF,00 after 256 steps. Mode=3 → 01,B8,5C,2E,17,B3; period 255 with out never 0.
4. Play pulse mid-run → Running=0 and out frozen for 20 cycles. Second Play → first Step arrives after the remaining held divider count. Play in the same cycle as a tick → no advance.
5. Begin dropped in the same cycle as Play and tick → IDLE, out=00, Step=0. Rst asserted mid-RUN → all outputs 0 on the next edge.
6. Speed changed 0→3 between ticks → the current interval completes at 2 cycles, and the next interval is 8 cycles.

Source files
------------

// File: rtl/light_pattern_engine_pkg.sv
// Shared definitions for the light pattern engine.
// Holds the engine state encoding, the pattern mode encoding and the helper
// that turns a speed code into a divider reload value.
package light_pattern_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MODE_ROTATE = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_COUNT  = 2'd2,
    MODE_LFSR   = 2'd3
  } mode_t;

  // The divider counts from (speed+1)*div_step-1 down to 0, so one tick
  // interval is exactly (speed+1)*div_step clock cycles.
  function automatic logic [31:0] tick_reload(input logic [3:0]  speed,
                                              input int unsigned div_step);
    return ((32'(speed) + 32'd1) * div_step) - 32'd1;
  endfunction

endpackage

// File: rtl/light_pattern_engine_tick_div.sv
// pattern_tick_div: reloadable down-counter that paces the pattern engine.
// Ports:
//   Clk, Rst : clock and synchronous active-high reset
//   load     : load the reload value for the current Speed
//   enable   : count this cycle (held when low)
//   Speed    : 4-bit speed code, sampled only when the counter (re)loads
//   tick     : high while enabled and the counter is at zero
module pattern_tick_div
  import light_pattern_engine_pkg::*;
#(
  parameter int unsigned DIV_STEP = 6250000,
  parameter int          DIV_BITS = 27
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       load,
  input  logic       enable,
  input  logic [3:0] Speed,
  output logic       tick
);

  logic [DIV_BITS-1:0] count;
  logic [DIV_BITS-1:0] reload;

  assign reload = DIV_BITS'(tick_reload(Speed, DIV_STEP));

  // Terminal count only matters while enabled, so a held count of zero
  // during a pause does not produce a tick.
  assign tick = enable && (count == '0);

  // Speed is sampled only here, on a load or on the terminal-count reload,
  // so a speed change never shortens or stretches the interval in progress.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      count <= '0;
    end else if (load) begin
      count <= reload;
    end else if (enable) begin
      if (count == '0) begin
        count <= reload;
      end else begin
        count <= count - DIV_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/light_pattern_engine.sv
// light_pattern_engine: speed-selectable LED pattern generator with
// run/pause control.
// Ports:
//   Clk, Rst : clock and synchronous active-high reset
//   Speed    : tick rate select, 0 fastest .. 15 slowest
//   Mode     : 0 rotate, 1 bounce, 2 count, 3 LFSR (latched at start)
//   Begin    : level, high runs the engine, low returns it to idle
//   Play     : one-cycle pulse toggling run/pause
//   out      : registered WIDTH-bit pattern
//   Step     : one-cycle pulse on the edge where out advances
//   Running  : high while in the run state
module light_pattern_engine
  import light_pattern_engine_pkg::*;
#(
  parameter int              WIDTH     = 8,
  parameter int unsigned     DIV_STEP  = 6250000,
  parameter int              DIV_BITS  = 27,
  parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(8'hB8)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [3:0]       Speed,
  input  logic [1:0]       Mode,
  input  logic             Begin,
  input  logic             Play,
  output logic [WIDTH-1:0] out,
  output logic             Step,
  output logic             Running
);

  state_t           state;
  mode_t            mode_q;
  logic             bounce_right;
  logic [WIDTH-1:0] next_out;
  logic             next_right;
  logic [WIDTH-1:0] seed;
  logic             div_load;
  logic             div_enable;
  logic             tick;

  // The divider loads on the start edge and only counts in RUN when neither
  // a stop nor a pause is requested, so it holds through the pause cycle.
  assign div_load   = (state == ST_IDLE) && Begin;
  assign div_enable = (state == ST_RUN) && Begin && !Play;

  pattern_tick_div #(
    .DIV_STEP(DIV_STEP),
    .DIV_BITS(DIV_BITS)
  ) u_tick_div (
    .Clk   (Clk),
    .Rst   (Rst),
    .load  (div_load),
    .enable(div_enable),
    .Speed (Speed),
    .tick  (tick)
  );

  assign seed = (mode_t'(Mode) == MODE_COUNT) ? '0 : WIDTH'(1);

  // Bounce turns around on the edge that leaves an endpoint, so each
  // endpoint is displayed for exactly one step.
  always_comb begin
    next_out   = out;
    next_right = bounce_right;
    case (mode_q)
      MODE_ROTATE: next_out = {out[WIDTH-2:0], out[WIDTH-1]};
      MODE_BOUNCE: begin
        if (!bounce_right) begin
          if (out[WIDTH-1]) begin
            next_out   = out >> 1;
            next_right = 1'b1;
          end else begin
            next_out = out << 1;
          end
        end else begin
          if (out[0]) begin
            next_out   = out << 1;
            next_right = 1'b0;
          end else begin
            next_out = out >> 1;
          end
        end
      end
      MODE_COUNT: next_out = out + WIDTH'(1);
      MODE_LFSR: begin
        if (out == '0) begin
          next_out = WIDTH'(1);
        end else begin
          next_out = (out >> 1) ^ (out[0] ? LFSR_TAPS : '0);
        end
      end
      default: next_out = out;
    endcase
  end

  // Control FSM with registered outputs. Begin low wins over Play and over
  // a tick; Play wins over a tick.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state        <= ST_IDLE;
      mode_q       <= MODE_ROTATE;
      bounce_right <= 1'b0;
      out          <= '0;
      Step         <= 1'b0;
      Running      <= 1'b0;
    end else begin
      Step <= 1'b0;
      case (state)
        ST_IDLE: begin
          out     <= '0;
          Running <= 1'b0;
          if (Begin) begin
            mode_q       <= mode_t'(Mode);
            bounce_right <= 1'b0;
            out          <= seed;
            Running      <= 1'b1;
            state        <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!Begin) begin
            out     <= '0;
            Running <= 1'b0;
            state   <= ST_IDLE;
          end else if (Play) begin
            Running <= 1'b0;
            state   <= ST_PAUSE;
          end else if (tick) begin
            out          <= next_out;
            bounce_right <= next_right;
            Step         <= 1'b1;
          end
        end
        ST_PAUSE: begin
          if (!Begin) begin
            out     <= '0;
            Running <= 1'b0;
            state   <= ST_IDLE;
          end else if (Play) begin
            Running <= 1'b1;
            state   <= ST_RUN;
          end
        end
        default: begin
          out     <= '0;
          Running <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_light_pattern_engine.sv
// Self-checking bench for light_pattern_engine (WIDTH=8, DIV_STEP=2).
// A table of pattern runs feeds a scoreboard of expected Step values;
// hand-written sequences cover pause/resume, stop and speed-change corners.
`timescale 1ns/1ps
module tb_light_pattern_engine;

  localparam int          WIDTH    = 8;
  localparam int unsigned DIV_STEP = 2;
  localparam int          DIV_BITS = 27;
  localparam logic [7:0]  TAPS     = 8'hB8;

  logic             Clk = 1'b0;
  logic             Rst;
  logic [3:0]       Speed;
  logic [1:0]       Mode;
  logic             Begin;
  logic             Play;
  logic [WIDTH-1:0] out;
  logic             Step;
  logic             Running;

  light_pattern_engine #(
    .WIDTH    (WIDTH),
    .DIV_STEP (DIV_STEP),
    .DIV_BITS (DIV_BITS),
    .LFSR_TAPS(TAPS)
  ) dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .Speed  (Speed),
    .Mode   (Mode),
    .Begin  (Begin),
    .Play   (Play),
    .out    (out),
    .Step   (Step),
    .Running(Running)
  );

  always #5 Clk = ~Clk;

  int compared   = 0;
  int mismatched = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [1:0] mode;
    logic [3:0] speed;
    int         steps;
    logic [7:0] final_out;
  } vec_t;

  vec_t vecs[9];

  task automatic step_clock();
    @(posedge Clk);
    #1;
  endtask

  task automatic applyStimulus(input logic b, input logic p,
                               input logic [3:0] s, input logic [1:0] m);
    Begin = b;
    Play  = p;
    Speed = s;
    Mode  = m;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: out=%02h expected %02h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkFlag(input string name, input logic actual, input logic expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkCount(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d cycles expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic wait_step(input int limit, output int cycles);
    cycles = 0;
    do begin
      step_clock();
      cycles++;
    end while (!Step && cycles < limit);
    if (!Step) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL step_timeout: no Step within %0d cycles", limit);
    end
  endtask

  task automatic go_idle();
    applyStimulus(1'b0, 1'b0, 4'd0, 2'd0);
    step_clock();
  endtask

  // Runs one table entry: the model pushes every expected pattern value,
  // each DUT Step pops one and also checks the spacing between steps.
  task automatic run_vector(input vec_t v);
    logic [7:0] cur;
    int         pos;
    bit         right;
    int         since;
    int         seen;
    int         period;
    int         limit;
    period = (int'(v.speed) + 1) * int'(DIV_STEP);
    cur    = (v.mode == 2'd2) ? 8'h00 : 8'h01;
    pos    = 0;
    right  = 1'b0;
    applyStimulus(1'b1, 1'b0, v.speed, v.mode);
    step_clock();
    checkOutput("seed", out, cur);
    checkFlag("running_after_start", Running, 1'b1);
    for (int i = 0; i < v.steps; i++) begin
      case (v.mode)
        2'd0: cur = {cur[6:0], cur[7]};
        2'd1: begin
          if (!right) begin
            if (pos == 7) begin
              right = 1'b1;
              pos   = 6;
            end else begin
              pos++;
            end
          end else begin
            if (pos == 0) begin
              right = 1'b0;
              pos   = 1;
            end else begin
              pos--;
            end
          end
          cur = 8'h01 << pos;
        end
        2'd2: cur = cur + 8'h01;
        default: cur = (cur == 8'h00) ? 8'h01 : ((cur >> 1) ^ (cur[0] ? TAPS : 8'h00));
      endcase
      exp_q.push_back(cur);
    end
    since = 0;
    seen  = 0;
    limit = v.steps * period + 10;
    for (int c = 0; c < limit && seen < v.steps; c++) begin
      step_clock();
      since++;
      if (Step) begin
        checkCount("step_interval", since, period);
        since = 0;
        if (exp_q.size() != 0) begin
          checkOutput("scoreboard_out", out, exp_q.pop_front());
        end
        seen++;
      end
    end
    if (seen < v.steps) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL vector_timeout: saw %0d steps expected %0d", seen, v.steps);
      exp_q.delete();
    end
    checkOutput("final_out", out, v.final_out);
    go_idle();
    checkOutput("idle_out", out, 8'h00);
    checkFlag("idle_running", Running, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cycles;

    vecs[0] = '{mode: 2'd0, speed: 4'd0, steps: 8,   final_out: 8'h01};
    vecs[1] = '{mode: 2'd0, speed: 4'd2, steps: 3,   final_out: 8'h08};
    vecs[2] = '{mode: 2'd1, speed: 4'd1, steps: 7,   final_out: 8'h80};
    vecs[3] = '{mode: 2'd1, speed: 4'd1, steps: 15,  final_out: 8'h02};
    vecs[4] = '{mode: 2'd2, speed: 4'd0, steps: 256, final_out: 8'h00};
    vecs[5] = '{mode: 2'd2, speed: 4'd1, steps: 5,   final_out: 8'h05};
    vecs[6] = '{mode: 2'd3, speed: 4'd0, steps: 5,   final_out: 8'hB3};
    vecs[7] = '{mode: 2'd3, speed: 4'd0, steps: 255, final_out: 8'h01};
    vecs[8] = '{mode: 2'd1, speed: 4'd0, steps: 22,  final_out: 8'h40};

    Rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 4'd0, 2'd0);
    step_clock();
    step_clock();
    checkOutput("reset_out", out, 8'h00);
    checkFlag("reset_step", Step, 1'b0);
    checkFlag("reset_running", Running, 1'b0);

    // Reset must win over Begin and Play
    applyStimulus(1'b1, 1'b1, 4'd0, 2'd0);
    step_clock();
    checkOutput("reset_override_out", out, 8'h00);
    checkFlag("reset_override_running", Running, 1'b0);
    Rst = 1'b0;
    go_idle();

    $display("[TB] table-driven pattern runs");
    for (int i = 0; i < 9; i++) begin
      run_vector(vecs[i]);
    end

    $display("[TB] pause and resume");
    applyStimulus(1'b1, 1'b0, 4'd3, 2'd0);
    step_clock();
    checkOutput("pause_seed", out, 8'h01);
    repeat (3) step_clock();
    applyStimulus(1'b1, 1'b1, 4'd3, 2'd0);
    step_clock();
    checkFlag("pause_running", Running, 1'b0);
    checkFlag("pause_step", Step, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'd3, 2'd0);
    for (int i = 0; i < 20; i++) begin
      step_clock();
      checkOutput("pause_hold_out", out, 8'h01);
      checkFlag("pause_hold_step", Step, 1'b0);
    end
    applyStimulus(1'b1, 1'b1, 4'd3, 2'd0);
    step_clock();
    checkFlag("resume_running", Running, 1'b1);
    applyStimulus(1'b1, 1'b0, 4'd3, 2'd0);
    wait_step(20, cycles);
    checkCount("resume_latency", cycles, 5);
    checkOutput("resume_out", out, 8'h02);

    $display("[TB] play coinciding with a tick");
    repeat (7) step_clock();
    checkFlag("pre_tick_step", Step, 1'b0);
    applyStimulus(1'b1, 1'b1, 4'd3, 2'd0);
    step_clock();
    checkFlag("play_tick_step", Step, 1'b0);
    checkOutput("play_tick_out", out, 8'h02);
    checkFlag("play_tick_running", Running, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'd3, 2'd0);
    step_clock();
    applyStimulus(1'b1, 1'b1, 4'd3, 2'd0);
    step_clock();
    applyStimulus(1'b1, 1'b0, 4'd3, 2'd0);
    wait_step(20, cycles);
    checkCount("held_zero_latency", cycles, 1);
    checkOutput("held_zero_out", out, 8'h04);
    go_idle();

    $display("[TB] stop with play and tick in the same cycle");
    applyStimulus(1'b1, 1'b0, 4'd0, 2'd0);
    step_clock();
    step_clock();
    applyStimulus(1'b0, 1'b1, 4'd0, 2'd0);
    step_clock();
    checkOutput("stop_out", out, 8'h00);
    checkFlag("stop_step", Step, 1'b0);
    checkFlag("stop_running", Running, 1'b0);
    go_idle();
    checkOutput("stop_idle_out", out, 8'h00);

    $display("[TB] reset mid-run and play during start");
    applyStimulus(1'b1, 1'b0, 4'd0, 2'd0);
    step_clock();
    repeat (4) step_clock();
    checkOutput("midrun_out", out, 8'h04);
    Rst = 1'b1;
    step_clock();
    checkOutput("midrun_reset_out", out, 8'h00);
    checkFlag("midrun_reset_step", Step, 1'b0);
    checkFlag("midrun_reset_running", Running, 1'b0);
    Rst = 1'b0;
    applyStimulus(1'b1, 1'b1, 4'd0, 2'd1);
    step_clock();
    checkFlag("start_play_running", Running, 1'b1);
    checkOutput("start_play_out", out, 8'h01);
    applyStimulus(1'b1, 1'b0, 4'd0, 2'd1);
    wait_step(20, cycles);
    checkCount("start_play_latency", cycles, 2);
    checkOutput("start_play_step_out", out, 8'h02);
    go_idle();

    $display("[TB] speed change between ticks");
    applyStimulus(1'b1, 1'b0, 4'd0, 2'd0);
    step_clock();
    applyStimulus(1'b1, 1'b0, 4'd3, 2'd2);
    wait_step(20, cycles);
    checkCount("speed_old_interval", cycles, 2);
    checkOutput("speed_old_out", out, 8'h02);
    wait_step(20, cycles);
    checkCount("speed_new_interval", cycles, 8);
    checkOutput("speed_mode_ignored_out", out, 8'h04);
    go_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
